// File: rtl/freq_div_prog.sv
// freq_div_prog: programmable square/pulse generator with a
// double-buffered terminal count applied only at period boundaries.
module freq_div_prog #(
    parameter int CNT_W      = 16,
    parameter int DEFAULT_TC = 666
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_in,
    input  logic             load,
    input  logic             sync,
    input  logic             mode,
    output logic             clk_out,
    output logic             tick,
    output logic             pending,
    output logic             cfg_err
);

    localparam logic [CNT_W-1:0] TC_RST = CNT_W'(DEFAULT_TC);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] act_q;
    logic [CNT_W-1:0] act_d;
    logic [CNT_W-1:0] shd_q;
    logic [CNT_W-1:0] shd_d;
    logic             pend_d;
    logic             out_d;
    logic             tick_d;
    logic             err_d;
    logic             term;
    logic             ld_ok;
    logic             ld_bad;

    assign term   = en && (cnt_q == act_q);
    assign ld_ok  = load && (tc_in != '0);
    assign ld_bad = load && (tc_in == '0);

    always_comb begin
        cnt_d  = cnt_q;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pending;
        out_d  = clk_out;
        tick_d = 1'b0;
        err_d  = ld_bad;

        // sync outranks the terminal count and the enable
        priority case (1'b1)
            sync: begin
                cnt_d = '0;
                out_d = 1'b0;
                if (pending) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end
            term: begin
                cnt_d  = '0;
                tick_d = 1'b1;
                out_d  = mode ? 1'b1 : ~clk_out;
                if (pending) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end
            default: begin
                if (en) begin
                    cnt_d = cnt_q + ONE;
                end
                if (mode) begin
                    out_d = 1'b0;
                end
            end
        endcase

        // a load in the same cycle lands after any apply above
        if (ld_ok) begin
            shd_d  = tc_in;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            act_q   <= TC_RST;
            shd_q   <= TC_RST;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            shd_q   <= shd_d;
            pending <= pend_d;
            clk_out <= out_d;
            tick    <= tick_d;
            cfg_err <= err_d;
        end
    end

endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: scoreboard bench for freq_div_prog with a
// countdown-based reference model and randomized stimulus.
module tb_freq_div_prog;

    localparam int CNT_W = 16;
    localparam int DTC   = 666;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic             sync = 1'b0;
    logic             mode = 1'b0;
    logic [CNT_W-1:0] tc_in = '0;
    logic             clk_out;
    logic             tick;
    logic             pending;
    logic             cfg_err;

    freq_div_prog #(
        .CNT_W     (CNT_W),
        .DEFAULT_TC(DTC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .tc_in  (tc_in),
        .load   (load),
        .sync   (sync),
        .mode   (mode),
        .clk_out(clk_out),
        .tick   (tick),
        .pending(pending),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    logic [3:0] exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    bit         mon_on = 1'b0;

    // reference model: remaining enabled cycles to the next boundary
    int m_act;
    int m_shd;
    int m_rem;
    bit m_pend;
    bit m_out;

    function automatic void model_reset();
        m_act  = DTC;
        m_shd  = DTC;
        m_rem  = DTC + 1;
        m_pend = 1'b0;
        m_out  = 1'b0;
    endfunction

    function automatic int m_cnt();
        return m_act + 1 - m_rem;
    endfunction

    task automatic check(input string name, input logic [3:0] got,
                         input logic [3:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s t=%0t got {clk_out,tick,pending,cfg_err}=%b want=%b",
                      name, $time, got, want);
    endtask

    // called at a negedge; drives inputs for the next rising edge
    task automatic drive(input bit e, input bit l, input int tc,
                         input bit s, input bit md);
        bit tk;
        en    = e;
        load  = l;
        tc_in = CNT_W'(tc);
        sync  = s;
        mode  = md;
        tk    = 1'b0;
        if (s) begin
            if (m_pend) begin
                m_act  = m_shd;
                m_pend = 1'b0;
            end
            m_rem = m_act + 1;
            m_out = 1'b0;
        end else if (e && m_rem == 1) begin
            tk = 1'b1;
            if (m_pend) begin
                m_act  = m_shd;
                m_pend = 1'b0;
            end
            m_rem = m_act + 1;
            m_out = md ? 1'b1 : ~m_out;
        end else begin
            if (e) m_rem--;
            if (md) m_out = 1'b0;
        end
        if (l && tc != 0) begin
            m_shd  = tc;
            m_pend = 1'b1;
        end
        exp_q.push_back({m_out, tk, m_pend, (l && tc == 0)});
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit md);
        repeat (n) drive(1'b1, 1'b0, 0, 1'b0, md);
    endtask

    // asserts reset between edges and checks outputs clear at once
    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_on = 1'b0;
        rst    = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset", {clk_out, tick, pending, cfg_err}, 4'b0000);
        load = 1'b0;
        sync = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        rst    = 1'b1;
        mon_on = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on && exp_q.size() > 0)
                check("cycle", {clk_out, tick, pending, cfg_err},
                      exp_q.pop_front());
        end
    end

    initial begin
        bit md;
        bit e;
        bit l;
        bit s;
        int tc;

        model_reset();
        do_reset();

        // default period, two full square cycles
        run(2 * (DTC + 1) + 20, 1'b0);

        // reload mid-period, applied at the next boundary
        while (m_cnt() != 300) run(1, 1'b0);
        drive(1'b1, 1'b1, 9, 1'b0, 1'b0);
        run(DTC + 60, 1'b0);

        // load coinciding with a boundary that applies an older value
        drive(1'b1, 1'b1, 9, 1'b0, 1'b0);
        while (m_rem != 1) run(1, 1'b0);
        drive(1'b1, 1'b1, 4, 1'b0, 1'b0);
        run(30, 1'b0);

        // rejected loads
        drive(1'b1, 1'b1, 0, 1'b0, 1'b0);
        run(3, 1'b0);
        drive(1'b1, 1'b1, 0, 1'b0, 1'b0);
        run(12, 1'b0);

        // pulse mode with an enable gap mid-period
        drive(1'b1, 1'b1, 3, 1'b0, 1'b1);
        while (m_pend) run(1, 1'b1);
        run(22, 1'b1);
        repeat (5) drive(1'b0, 1'b0, 0, 1'b0, 1'b1);
        run(20, 1'b1);

        // sync with a pending value, then reset mid-period
        do_reset();
        while (m_cnt() != 100) run(1, 1'b0);
        drive(1'b1, 1'b1, 19, 1'b0, 1'b0);
        while (m_cnt() != 200) run(1, 1'b0);
        drive(1'b1, 1'b0, 0, 1'b1, 1'b0);
        run(50, 1'b0);
        while (!m_out) run(1, 1'b0);
        drive(1'b1, 1'b1, 7, 1'b0, 1'b0);
        do_reset();
        run(DTC + 10, 1'b0);

        // randomized traffic on short periods
        drive(1'b1, 1'b1, 5, 1'b0, 1'b0);
        md = 1'b0;
        repeat (3000) begin
            e  = ($urandom_range(0, 9) != 0);
            l  = ($urandom_range(0, 19) == 0);
            tc = $urandom_range(0, 15);
            s  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) md = ~md;
            drive(e, l, tc, s, md);
        end

        repeat (3) @(posedge clk);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain left=%0d want=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
